// File: rtl/bf16_result_drain_pkg.sv
// Shared types and constants for the BF16 row result drain.
package drain_pkg;

  typedef logic [15:0] bf16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REARM = 2'd2
  } drain_state_e;

  localparam bf16_t BF16_QNAN = 16'h7FC0;

endpackage

// File: rtl/bf16_result_drain_if.sv
// Output stream of the drain: one BF16 word per valid/ready beat.
interface bf16_result_drain_if #(
  parameter int IDX_W = 2
);
  import drain_pkg::*;

  logic             out_valid;
  logic             out_ready;
  bf16_t            out_data;
  logic [IDX_W-1:0] out_col;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_col,
                  output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_col,
                  input out_last, output out_ready);
endinterface

// File: rtl/bf16_nan_canon.sv
// Per-column NaN canonicaliser: any NaN becomes the canonical quiet NaN,
// everything else (including infinities) passes through.
// Only compiled when DRAIN_NAN_CANON_EN is defined.
`ifdef DRAIN_NAN_CANON_EN
module bf16_nan_canon
  import drain_pkg::*;
(
  input  bf16_t din,
  output bf16_t dout
);
  logic is_nan;

  // exp all ones with non-zero mantissa
  always_comb begin
    is_nan = (din[14:7] == 8'hFF) && (din[6:0] != 7'd0);
    dout   = is_nan ? BF16_QNAN : din;
  end
endmodule
`endif

// File: rtl/bf16_result_drain.sv
// Row result drain: waits for the whole row of mac_cells to hold a result,
// snapshots it, pulses clear_accum back, then streams one column per beat.
// Optional build macro: DRAIN_NAN_CANON_EN (canonicalise NaNs at capture).
module bf16_result_drain
  import drain_pkg::*;
#(
  parameter int COLS  = 4,
  parameter int IDX_W = (COLS > 1) ? $clog2(COLS) : 1
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COLS-1:0]        mac_valid_i,
  input  bf16_t [COLS-1:0]       mac_bf_i,
  input  logic                   flush_i,
  output logic                   clear_accum_o,
  bf16_result_drain_if.master    out,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(COLS - 1);

  drain_state_e         state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nx;
  bf16_t [COLS-1:0]     snap;
  bf16_t [COLS-1:0]     cap_w;

  // per-column capture path
  for (genvar i = 0; i < COLS; i++) begin : g_col
`ifdef DRAIN_NAN_CANON_EN
    bf16_nan_canon u_canon (.din(mac_bf_i[i]), .dout(cap_w[i]));
`else
    assign cap_w[i] = mac_bf_i[i];
`endif
  end

  assign idx_nx      = idx + IDX_W'(1);
  assign busy        = (state != IDLE);
  assign out.out_col = idx;

  // capture / drain / rearm sequencing; flush overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      snap          <= '0;
      frame_cnt     <= '0;
      clear_accum_o <= 1'b0;
      out.out_valid <= 1'b0;
      out.out_data  <= '0;
      out.out_last  <= 1'b0;
    end else begin
      clear_accum_o <= 1'b0;
      if (flush_i) begin
        state         <= REARM;
        idx           <= '0;
        snap          <= '0;
        clear_accum_o <= 1'b1;
        out.out_valid <= 1'b0;
        out.out_data  <= '0;
        out.out_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // partial validity is ignored: wait for the full row
            if (&mac_valid_i) begin
              snap          <= cap_w;
              idx           <= '0;
              clear_accum_o <= 1'b1;
              out.out_valid <= 1'b1;
              out.out_data  <= cap_w[0];
              out.out_last  <= (COLS == 1);
              state         <= DRAIN;
            end
          end
          DRAIN: begin
            if (out.out_valid && out.out_ready) begin
              if (idx == LAST) begin
                frame_cnt     <= frame_cnt + 16'd1;
                out.out_valid <= 1'b0;
                out.out_last  <= 1'b0;
                state         <= REARM;
              end else begin
                idx          <= idx_nx;
                out.out_data <= snap[idx_nx];
                out.out_last <= (idx_nx == LAST);
              end
            end
          end
          REARM: begin
            // mac_valid lags clear_accum; wait for it to drop so the stale
            // result is not captured twice
            if (mac_valid_i == '0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bf16_result_drain.sv
// Directed bench for bf16_result_drain (COLS=4): table-driven frames plus
// hand-written backpressure, partial-valid, flush, rearm and reset sequences.
module tb_bf16_result_drain;
  import drain_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        mac_valid;
  logic [3:0][15:0]  mac_bf;
  logic              flush;
  logic              clear;
  logic              busy;
  logic [15:0]       fc;

  int n_run  = 0;
  int n_fail = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  bf16_result_drain_if #(.IDX_W(2)) dif ();

  bf16_result_drain #(.COLS(4), .IDX_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mac_valid_i   (mac_valid),
    .mac_bf_i      (mac_bf),
    .flush_i       (flush),
    .clear_accum_o (clear),
    .out           (dif),
    .busy          (busy),
    .frame_cnt     (fc)
  );

  typedef struct {
    logic [3:0][15:0] din;
    logic [3:0][15:0] dexp;
  } vec_t;

  vec_t vt [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // present and accept beats from..to with out_ready high
  task automatic drain_beats(input logic [3:0][15:0] e, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      chk($sformatf("valid c%0d", c), dif.out_valid, 1);
      chk($sformatf("data c%0d", c), dif.out_data, e[c]);
      chk($sformatf("col c%0d", c), dif.out_col, c);
      chk($sformatf("last c%0d", c), dif.out_last, (c == 3));
      if (c > 0) chk($sformatf("noclear c%0d", c), clear, 0);
      tick();
    end
  endtask

  task automatic capture(input logic [3:0][15:0] d);
    mac_bf    = d;
    mac_valid = 4'hF;
    tick();
    chk("cap clear", clear, 1);
    chk("cap busy", busy, 1);
  endtask

  task automatic finish_frame();
    exp_fc++;
    chk("rearm valid", dif.out_valid, 0);
    chk("rearm busy", busy, 1);
    chk("frame_cnt", fc, exp_fc);
    mac_valid = 4'h0;
    tick();
    chk("idle busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][15:0] e;
    vt[0].din  = {16'h4080, 16'h4040, 16'h4000, 16'h3F80};
    vt[0].dexp = {16'h4080, 16'h4040, 16'h4000, 16'h3F80};
    vt[1].din  = {16'h0001, 16'h7F80, 16'hFF80, 16'h7F81};
    vt[2].din  = {16'h1234, 16'h8000, 16'hFFFF, 16'h0000};
`ifdef DRAIN_NAN_CANON_EN
    vt[1].dexp = {16'h0001, 16'h7F80, 16'hFF80, 16'h7FC0};
    vt[2].dexp = {16'h1234, 16'h8000, 16'h7FC0, 16'h0000};
`else
    vt[1].dexp = {16'h0001, 16'h7F80, 16'hFF80, 16'h7F81};
    vt[2].dexp = {16'h1234, 16'h8000, 16'hFFFF, 16'h0000};
`endif

    rst_n         = 1'b0;
    mac_valid     = 4'h0;
    mac_bf        = '0;
    flush         = 1'b0;
    dif.out_ready = 1'b1;
    #12;
    chk("rst valid", dif.out_valid, 0);
    chk("rst clear", clear, 0);
    chk("rst busy", busy, 0);
    chk("rst data", dif.out_data, 0);
    chk("rst col", dif.out_col, 0);
    chk("rst last", dif.out_last, 0);
    chk("rst fc", fc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // table-driven frames, out_ready held high
    for (int v = 0; v < 3; v++) begin
      capture(vt[v].din);
      drain_beats(vt[v].dexp, 0, 3);
      finish_frame();
    end

    // backpressure on col1 for 3 cycles
    e = vt[0].dexp;
    capture(vt[0].din);
    drain_beats(e, 0, 0);
    dif.out_ready = 1'b0;
    repeat (3) begin
      chk("bp valid", dif.out_valid, 1);
      chk("bp data", dif.out_data, 16'h4000);
      chk("bp col", dif.out_col, 1);
      tick();
    end
    dif.out_ready = 1'b1;
    drain_beats(e, 1, 3);
    finish_frame();

    // partial validity ignored, then completing the row captures
    mac_bf    = vt[2].din;
    mac_valid = 4'b0111;
    repeat (10) begin
      tick();
      chk("partial quiet", {clear, dif.out_valid, busy}, 3'b000);
    end
    mac_valid = 4'hF;
    tick();
    chk("partial cap clear", clear, 1);
    drain_beats(vt[2].dexp, 0, 3);
    finish_frame();

    // flush during col2, together with a handshake
    capture(vt[0].din);
    drain_beats(vt[0].dexp, 0, 1);
    chk("pre-flush col", dif.out_col, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush valid", dif.out_valid, 0);
    chk("flush clear", clear, 1);
    chk("flush busy", busy, 1);
    chk("flush fc", fc, exp_fc);
    tick();
    chk("flush clear once", clear, 0);
    chk("flush holds rearm", busy, 1);
    mac_valid = 4'h0;
    tick();
    chk("flush idle", busy, 0);
    chk("flush fc after", fc, exp_fc);

    // mac_valid held high after drain: no recapture until it drops
    capture(vt[1].din);
    drain_beats(vt[1].dexp, 0, 3);
    exp_fc++;
    repeat (5) begin
      chk("hold rearm", {busy, dif.out_valid, clear}, 3'b100);
      tick();
    end
    mac_valid = 4'h0;
    tick();
    chk("hold idle", busy, 0);
    capture(vt[0].din);
    drain_beats(vt[0].dexp, 0, 3);
    finish_frame();

    // reset mid-drain
    capture(vt[0].din);
    drain_beats(vt[0].dexp, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst valid", dif.out_valid, 0);
    chk("mrst busy", busy, 0);
    chk("mrst fc", fc, 0);
    chk("mrst data", dif.out_data, 0);
    chk("mrst col", dif.out_col, 0);
    chk("mrst clear", clear, 0);
    exp_fc    = 0;
    mac_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post rst clear", clear, 0);
    capture(vt[2].din);
    drain_beats(vt[2].dexp, 0, 3);
    finish_frame();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
